// File: rtl/uc_soma.sv
// Sequencing controller for a floating-point adder datapath: align, add,
// normalise, round. Outputs are decoded from the current state and the status inputs.
module uc_soma (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] diferenca_exp,
  input  logic       sum_cout,
  input  logic       sum_msb,
  input  logic       sum_zero,
  input  logic       round_up,
  input  logic [7:0] exp_res,
  output logic       BigAlu_in_A,
  output logic       BigAlu_in_B,
  output logic       ShiftDif_amount,
  output logic       Exp_sel,
  output logic       ShiftNorm_sel,
  output logic       ShiftNorm_amount,
  output logic       Increment_sel,
  output logic       Increment_amount,
  output logic       Roud_amount,
  output logic       ld_sum,
  output logic       ld_exp,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic       unf,
  output logic       align_sat
);

  // state | meaning
  // IDLE  | waiting for start, all outputs low
  // ALIGN | shift smaller operand, load max exponent
  // ADD   | load mantissa sum
  // NORM  | one normalisation step per cycle
  // ROUND | apply rounding increment
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_norm_cnt;
  logic       r_round_used;
  logic       r_ovf;
  logic       r_unf;
  logic       r_align_sat;

  logic [8:0] w_dif_mag;
  logic       w_sat;
  logic       w_sat_now;
  logic       w_set_ovf;
  logic       w_set_unf;
  logic       w_set_round;
  logic       w_cnt_inc;
  logic       w_accept;
  logic       w_release;

  // 9-bit magnitude so that -128 comes out as 128 rather than wrapping
  assign w_dif_mag = diferenca_exp[7] ? (9'd0 - {1'b1, diferenca_exp})
                                      : {1'b0, diferenca_exp};
  assign w_sat     = (w_dif_mag > 9'd24);
  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_release = (r_state == S_DONE);

  always_comb begin
    w_next           = r_state;
    BigAlu_in_A      = 1'b0;
    BigAlu_in_B      = 1'b0;
    ShiftDif_amount  = 1'b0;
    Exp_sel          = 1'b0;
    ShiftNorm_sel    = 1'b0;
    ShiftNorm_amount = 1'b0;
    Increment_sel    = 1'b0;
    Increment_amount = 1'b0;
    Roud_amount      = 1'b0;
    ld_sum           = 1'b0;
    ld_exp           = 1'b0;
    done             = 1'b0;
    w_sat_now        = 1'b0;
    w_set_ovf        = 1'b0;
    w_set_unf        = 1'b0;
    w_set_round      = 1'b0;
    w_cnt_inc        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ALIGN;
      end
      S_ALIGN: begin
        ShiftDif_amount = 1'b1;
        ld_exp          = 1'b1;
        BigAlu_in_A     = diferenca_exp[7];
        BigAlu_in_B     = ~diferenca_exp[7];
        w_sat_now       = w_sat;
        w_next          = S_ADD;
      end
      S_ADD: begin
        BigAlu_in_A = diferenca_exp[7];
        BigAlu_in_B = ~diferenca_exp[7];
        ld_sum      = 1'b1;
        w_next      = S_NORM;
      end
      S_NORM: begin
        if (sum_zero) begin
          w_next = S_DONE;
        end else if (sum_cout) begin
          ShiftNorm_sel    = 1'b1;
          ShiftNorm_amount = 1'b1;
          Increment_sel    = 1'b1;
          Increment_amount = 1'b1;
          ld_sum           = 1'b1;
          ld_exp           = 1'b1;
          Exp_sel          = 1'b1;
          w_set_ovf        = (exp_res == 8'hFE);
          w_next           = w_set_ovf ? S_DONE : S_ROUND;
        end else if (!sum_msb) begin
          ShiftNorm_amount = 1'b1;
          Increment_amount = 1'b1;
          ld_sum           = 1'b1;
          ld_exp           = 1'b1;
          Exp_sel          = 1'b1;
          w_cnt_inc        = 1'b1;
          w_set_unf        = (exp_res == 8'h01);
          // the 24th left shift ends normalisation even if msb never shows up
          if (w_set_unf)                    w_next = S_DONE;
          else if (r_norm_cnt == 5'd23)     w_next = S_ROUND;
        end else begin
          w_next = S_ROUND;
        end
      end
      S_ROUND: begin
        Roud_amount = round_up;
        ld_sum      = round_up;
        if (round_up && !r_round_used) begin
          w_set_round = 1'b1;
          w_next      = S_NORM;
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign ovf       = r_ovf | w_set_ovf;
  assign unf       = r_unf | w_set_unf;
  assign align_sat = r_align_sat | w_sat_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_norm_cnt   <= 5'd0;
      r_round_used <= 1'b0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_align_sat  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept || w_release) begin
        r_round_used <= 1'b0;
        r_ovf        <= 1'b0;
        r_unf        <= 1'b0;
        r_align_sat  <= 1'b0;
      end else begin
        if (w_set_round) r_round_used <= 1'b1;
        if (w_set_ovf)   r_ovf        <= 1'b1;
        if (w_set_unf)   r_unf        <= 1'b1;
        if (w_sat_now)   r_align_sat  <= 1'b1;
      end
      if ((r_state != S_NORM) && (w_next == S_NORM)) r_norm_cnt <= 5'd0;
      else if (w_cnt_inc)                            r_norm_cnt <= r_norm_cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_uc_soma.sv
// Closed-loop bench: an abstract mantissa/exponent datapath answers the
// controller, and results are compared against an arithmetic normalisation model.
module tb_uc_soma;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] diferenca_exp, exp_res;
  logic       sum_cout, sum_msb, sum_zero, round_up;
  logic       BigAlu_in_A, BigAlu_in_B, ShiftDif_amount, Exp_sel, ShiftNorm_sel;
  logic       ShiftNorm_amount, Increment_sel, Increment_amount, Roud_amount;
  logic       ld_sum, ld_exp, busy, done, ovf, unf, align_sat;

  uc_soma dut (
    .clk(clk), .rst(rst), .start(start), .diferenca_exp(diferenca_exp),
    .sum_cout(sum_cout), .sum_msb(sum_msb), .sum_zero(sum_zero),
    .round_up(round_up), .exp_res(exp_res),
    .BigAlu_in_A(BigAlu_in_A), .BigAlu_in_B(BigAlu_in_B),
    .ShiftDif_amount(ShiftDif_amount), .Exp_sel(Exp_sel),
    .ShiftNorm_sel(ShiftNorm_sel), .ShiftNorm_amount(ShiftNorm_amount),
    .Increment_sel(Increment_sel), .Increment_amount(Increment_amount),
    .Roud_amount(Roud_amount), .ld_sum(ld_sum), .ld_exp(ld_exp),
    .busy(busy), .done(done), .ovf(ovf), .unf(unf), .align_sat(align_sat)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [24:0] m_dp, cur_m0;
  logic [7:0]  e_dp, cur_e0;
  bit          stuck_mode;
  int          nl, nr;
  logic p_ld_sum, p_ld_exp, p_exp_sel, p_nsel, p_namt, p_isel, p_iamt, p_rnd;

  function automatic logic [15:0] outs();
    return {BigAlu_in_A, BigAlu_in_B, ShiftDif_amount, Exp_sel, ShiftNorm_sel,
            ShiftNorm_amount, Increment_sel, Increment_amount, Roud_amount,
            ld_sum, ld_exp, busy, done, ovf, unf, align_sat};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lz24(input logic [24:0] m);
    int k = 0;
    for (int b = 23; b >= 0; b--) begin
      if (m[b]) break;
      k++;
    end
    return k;
  endfunction

  // Expected edge (counted from the start edge) at which done appears, plus final values.
  function automatic void predict(input logic [24:0] m0, input logic [7:0] e0, input bit r,
                                  output int cyc, output logic [24:0] mf, output logic [7:0] ef,
                                  output bit ov, output bit un, output int el, output int er);
    logic [24:0] m = m0;
    int e = e0;
    int k;
    bit fin = 0;
    cyc = 2; ov = 0; un = 0; el = 0; er = 0;
    for (int pass = 0; pass < 2 && !fin; pass++) begin
      cyc++;
      if (m == 25'd0) begin
        cyc++; fin = 1;
      end else if (m[24]) begin
        m = m >> 1; er++;
        if (e == 254) begin e = 255; ov = 1; cyc++; fin = 1; end
        else e = e + 1;
      end else if (!m[23]) begin
        k = lz24(m);
        if (e <= k) begin
          m = m << e; el += e; cyc += e; e = 0; un = 1; fin = 1;
        end else begin
          m = m << k; el += k; e = e - k; cyc += k;
        end
      end
      if (!fin) begin
        cyc++;
        if (r) m = m + 25'd1;
        if (!(r && pass == 0)) begin cyc++; fin = 1; end
      end
    end
    mf = m; ef = e[7:0];
  endfunction

  task automatic drive_status();
    sum_cout = stuck_mode ? 1'b0 : m_dp[24];
    sum_msb  = stuck_mode ? 1'b0 : m_dp[23];
    sum_zero = stuck_mode ? 1'b0 : (m_dp == 25'd0);
    exp_res  = e_dp;
  endtask

  task automatic update_model();
    if (p_ld_exp && !p_exp_sel)    e_dp = cur_e0;
    else if (p_ld_exp && p_iamt)   e_dp = p_isel ? e_dp + 8'd1 : e_dp - 8'd1;
    if (p_ld_sum) begin
      if (p_namt) begin
        if (p_nsel) begin m_dp = m_dp >> 1; nr++; end
        else        begin m_dp = m_dp << 1; nl++; end
      end else if (p_rnd) m_dp = m_dp + 25'd1;
      else                m_dp = cur_m0;
    end
  endtask

  task automatic run_op(input logic [7:0] diff, input logic [24:0] m0, input logic [7:0] e0,
                        input bit r, input bit stuck, input bit hold_start);
    int exp_cyc, exp_el, exp_er, done_edge, mag;
    logic [24:0] exp_m;
    logic [7:0]  exp_e;
    bit exp_ov, exp_un, exp_sat, got_done;
    if (stuck) begin
      exp_cyc = 28; exp_el = 24; exp_er = 0; exp_m = 25'd0;
      exp_e = e0 - 8'd24; exp_ov = 0; exp_un = 0;
    end else begin
      predict(m0, e0, r, exp_cyc, exp_m, exp_e, exp_ov, exp_un, exp_el, exp_er);
    end
    mag = $signed(diff);
    if (mag < 0) mag = -mag;
    exp_sat = (mag > 24);
    cur_m0 = m0; cur_e0 = e0; stuck_mode = stuck;
    nl = 0; nr = 0; done_edge = -1; got_done = 0;
    {p_ld_sum, p_ld_exp, p_exp_sel, p_nsel, p_namt, p_isel, p_iamt, p_rnd} = '0;
    diferenca_exp = diff; round_up = r; start = 1'b1;
    drive_status();
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    for (int c = 1; c <= 80 && !got_done; c++) begin
      if (c > 1) update_model();
      drive_status();
      @(negedge clk);
      p_ld_sum = ld_sum; p_ld_exp = ld_exp; p_exp_sel = Exp_sel; p_nsel = ShiftNorm_sel;
      p_namt = ShiftNorm_amount; p_isel = Increment_sel; p_iamt = Increment_amount;
      p_rnd = Roud_amount;
      if (c == 1) begin
        chk("align_ctrl", 32'({ShiftDif_amount, ld_exp, Exp_sel, ld_sum}), 32'b1100);
        chk("align_alu", 32'({BigAlu_in_A, BigAlu_in_B}), 32'({diff[7], ~diff[7]}));
        chk("align_sat_now", 32'(align_sat), 32'(exp_sat));
      end
      if (done) begin got_done = 1; done_edge = c; end
      else begin @(posedge clk); #1; end
      if (c == 20) start = 1'b0;
    end
    start = 1'b0;
    chk("done_edge", 32'(done_edge), 32'(exp_cyc));
    chk("busy_at_done", 32'(busy), 32'(got_done));
    chk("left_shifts", 32'(nl), 32'(exp_el));
    chk("right_shifts", 32'(nr), 32'(exp_er));
    chk("exp_final", 32'(e_dp), 32'(exp_e));
    if (!stuck) chk("mant_final", 32'(m_dp), 32'(exp_m));
    chk("flags_ovf_unf_sat", 32'({ovf, unf, align_sat}), 32'({exp_ov, exp_un, exp_sat}));
    @(posedge clk); #1;
    stuck_mode = 0;
    @(negedge clk);
    chk("idle_outs", 32'(outs()), 32'd0);
  endtask

  initial begin
    logic [24:0] m0;
    logic [7:0]  e0;
    int          k;
    rst = 1'b1; start = 1'b0; diferenca_exp = 8'd0; round_up = 1'b0;
    m_dp = 25'd0; e_dp = 8'd0; cur_m0 = 25'd0; cur_e0 = 8'd0; stuck_mode = 0;
    drive_status();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'(outs()), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'(outs()), 32'd0);

    run_op(8'h03, 25'h0C00000, 8'd50,  0, 0, 0);
    run_op(8'hFE, 25'h1400000, 8'd60,  0, 0, 0);
    run_op(8'h10, 25'h0100000, 8'd40,  0, 0, 0);
    run_op(8'h01, 25'h1000001, 8'hFE,  0, 0, 0);
    run_op(8'h80, 25'h0800000, 8'd30,  0, 0, 0);
    run_op(8'h05, 25'h0100000, 8'h01,  0, 0, 0);
    run_op(8'h00, 25'h0FFFFFF, 8'd10,  1, 0, 0);
    run_op(8'h18, 25'h0800000, 8'd10,  1, 0, 0);
    run_op(8'h19, 25'h0000000, 8'd20,  1, 0, 0);
    run_op(8'hE8, 25'h0000001, 8'd100, 0, 1, 1);

    for (int i = 0; i < 40; i++) begin
      e0 = 8'($urandom_range(1, 254));
      if ($urandom_range(0, 7) == 0) e0 = 8'hFE;
      if ($urandom_range(0, 7) == 0) e0 = 8'($urandom_range(1, 4));
      case ($urandom_range(0, 3))
        0: m0 = 25'd0;
        1: m0 = {1'b1, 24'($urandom)};
        2: m0 = {2'b01, 23'($urandom)};
        default: begin
          k  = $urandom_range(1, 23);
          m0 = (25'h0800000 >> k) | (25'($urandom) & ((25'h0800000 >> k) - 25'd1));
        end
      endcase
      run_op(8'($urandom), m0, e0, 1'($urandom_range(0, 1)), 0, 0);
    end

    // reset while normalising: operation is abandoned
    stuck_mode = 1; e_dp = 8'd80; drive_status();
    diferenca_exp = 8'h02; round_up = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_norm_shift", 32'({busy, ShiftNorm_amount}), 32'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid_op_outs", 32'(outs()), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("no_done_after_reset", 32'({done, busy}), 32'd0);
    end
    stuck_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uc_soma.md
UC_SOMA -- requirements
Module: uc_soma

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the clk rising edge.
REQ-003 SHALL have port start, input, 1 bit: request one addition of the operands currently held by the datapath.
REQ-004 SHALL have port diferenca_exp, input, 8 bits: exp_A minus exp_B from the small ALU, two's complement.
REQ-005 SHALL have port sum_cout, input, 1 bit: carry out of the big-ALU mantissa sum.
REQ-006 SHALL have port sum_msb, input, 1 bit: bit 23 (hidden-1 position) of the current mantissa.
REQ-007 SHALL have port sum_zero, input, 1 bit: current mantissa equals zero.
REQ-008 SHALL have port round_up, input, 1 bit: guard/round/sticky decision says increment.
REQ-009 SHALL have port exp_res, input, 8 bits: current result exponent register.
REQ-010 SHALL have ports BigAlu_in_A and BigAlu_in_B, outputs, 1 bit each: BigAlu_in_A=1 routes the aligned (shifted) mantissa to ALU port A; BigAlu_in_B is its complement.
REQ-011 SHALL have port ShiftDif_amount, output, 1 bit: apply the alignment shift of |diferenca_exp|.
REQ-012 SHALL have port Exp_sel, output, 1 bit: 0 = exponent register loads max(exp_A,exp_B); 1 = loads the incrementer output.
REQ-013 SHALL have port ShiftNorm_sel, output, 1 bit: 1 = right shift, 0 = left shift.
REQ-014 SHALL have port ShiftNorm_amount, output, 1 bit: shift the mantissa by one this cycle.
REQ-015 SHALL have port Increment_sel, output, 1 bit: 1 = +1, 0 = -1.
REQ-016 SHALL have port Increment_amount, output, 1 bit: change the exponent by one this cycle.
REQ-017 SHALL have port Roud_amount, output, 1 bit: add one ulp to the mantissa.
REQ-018 SHALL have ports ld_sum and ld_exp, outputs, 1 bit each: load enables for the datapath mantissa and exponent registers.
REQ-019 SHALL have ports busy, done, ovf, unf and align_sat, outputs, 1 bit each.

Function
REQ-020 SHALL implement the states IDLE, ALIGN, ADD, NORM, ROUND, DONE with a registered state; all outputs SHALL be decoded combinationally from the state and the status inputs.
REQ-021 IDLE: all outputs 0; start=1 SHALL move the block to ALIGN on the next edge; start in any other state SHALL be ignored.
REQ-022 ALIGN (1 cycle): ShiftDif_amount=1, ld_exp=1, Exp_sel=0; BigAlu_in_A = diferenca_exp[7]; align_sat=1 when |diferenca_exp|>24, where -128 is treated as magnitude 128; next state ADD.
REQ-023 ADD (1 cycle): ld_sum=1; next state NORM.
REQ-024 NORM, priority order:
  - sum_zero: go to DONE, no shift.
  - sum_cout: right shift, +1 exponent, go to ROUND.
  - !sum_msb: left shift, -1 exponent, stay in NORM, increment the 5-bit norm counter.
  - otherwise: go to ROUND.
REQ-025 Each NORM shift SHALL assert ld_sum=1 and ld_exp=1 together with Exp_sel=1.
REQ-026 The norm counter SHALL clear on entry to NORM; on reaching 24 the block SHALL go to ROUND regardless of sum_msb.
REQ-027 Overflow: an increment with exp_res=8'hFE SHALL set ovf and go to DONE.
REQ-028 Underflow: a decrement with exp_res=8'h01 SHALL set unf and go to DONE.
REQ-029 ROUND (1 cycle): Roud_amount=round_up and ld_sum=round_up; next state NORM when round_up=1 (post-round carry re-check, allowed once per operation, tracked by a flag), else DONE.
REQ-030 DONE (1 cycle): done=1; next state IDLE.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 ovf, unf and align_sat SHALL be registered, SHALL clear on start acceptance, and SHALL hold through DONE.
REQ-033 Minimum latency: done asserted on the 5th edge after the start edge (ALIGN, ADD, NORM, ROUND, DONE).
REQ-034 Maximum latency: 24 left shifts plus one re-NORM pass.

Reset
REQ-035 rst=1 SHALL force IDLE, clear the norm counter, the round flag, ovf, unf and align_sat, and drive all outputs to 0 on the next edge, including mid-operation.
REQ-036 A result in progress when reset is applied SHALL be abandoned, and done SHALL NOT assert for it.

Verification
REQ-037 Scenario: diferenca_exp=8'h03, sum_msb=1, round_up=0 -> ALIGN with BigAlu_in_A=0; done on the 5th edge; no shifts.
REQ-038 Scenario: diferenca_exp=8'hFE, sum_cout=1 -> BigAlu_in_A=1; one right shift with Increment_sel=1.
REQ-039 Scenario: sum_msb=0 for 3 NORM cycles, then 1 -> exactly 3 left shifts and 3 decrements; done on the 8th edge.
REQ-040 Scenario: exp_res=8'hFE with sum_cout=1 -> ovf=1 and done=1, with no ROUND cycle.
REQ-041 Scenario: diferenca_exp=8'h80 -> align_sat=1.
REQ-042 Scenario: rst pulsed during NORM -> IDLE on the next edge; outputs 0; done never asserts.
